// File: rtl/mod_cnt_pkg.sv
// Shared types, defaults and the modulo-successor helper used by the MOD-N
// counter blocks and by the receive-side sequence checker.
package mod_cnt_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } seq_state_t;

    localparam int MOD_DEFAULT   = 14;
    localparam int CNT_W_DEFAULT = 8;

    // Successor in the 0..mod-1 ring; callers cast the result down to their bus width.
    function automatic logic [15:0] mod_next(input logic [15:0] v, input logic [15:0] mod);
        logic [15:0] r_result;
        if (v == (mod - 16'd1)) begin
            r_result = 16'd0;
        end else begin
            r_result = v + 16'd1;
        end
        return r_result;
    endfunction

endpackage

// File: rtl/mod_seq_checker_sat_counter.sv
// Saturating event counter with a synchronous clear that beats a same-cycle increment.
module sat_counter
    import mod_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/mod_seq_checker.sv
// Receive-side checker for a modulo-MOD count stream: locks onto the sequence,
// then reports mismatches / out-of-range samples and counts wrap-arounds.
module mod_seq_checker
    import mod_cnt_pkg::*;
#(
    parameter int MOD      = MOD_DEFAULT,
    parameter int W        = 4,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_count,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    localparam int                GOOD_W    = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

    seq_state_t        r_state;
    logic [W-1:0]      r_expected;
    logic [GOOD_W-1:0] r_good;
    logic              r_locked;
    logic              r_err_pulse;
    logic              r_wrap_pulse;

    seq_state_t        w_state_nxt;
    logic [W-1:0]      w_expected_nxt;
    logic [GOOD_W-1:0] w_good_nxt;
    logic              w_err;
    logic              w_wrap;
    logic              w_in_range;
    logic              w_match;
    logic              w_is_zero;
    logic [W-1:0]      w_nxt;

    // The extra bit keeps the range test correct even when MOD == 2^W.
    assign w_in_range = ({1'b0, in_count} < (W + 1)'(MOD));
    assign w_match    = (in_count == r_expected);
    assign w_is_zero  = (in_count == {W{1'b0}});
    assign w_nxt      = W'(mod_next(16'(in_count), 16'(MOD)));

    // Next-state, reseed and error/wrap decisions for the current sample.
    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_good_nxt     = r_good;
        w_err          = 1'b0;
        w_wrap         = 1'b0;
        if (in_valid) begin
            case (r_state)
                SEARCH: begin
                    if (w_in_range) begin
                        w_expected_nxt = w_nxt;
                        w_good_nxt     = {GOOD_W{1'b0}};
                        w_state_nxt    = ACQUIRE;
                    end else begin
                        w_state_nxt    = SEARCH;
                    end
                end
                ACQUIRE: begin
                    if (!w_in_range) begin
                        w_good_nxt     = {GOOD_W{1'b0}};
                        w_state_nxt    = SEARCH;
                    end else if (w_match) begin
                        w_expected_nxt = w_nxt;
                        if (r_good == GOOD_LAST) begin
                            w_good_nxt  = GOOD_LOCK;
                            w_state_nxt = LOCKED;
                        end else begin
                            w_good_nxt  = r_good + GOOD_W'(1);
                        end
                    end else begin
                        w_expected_nxt = w_nxt;
                        w_good_nxt     = {GOOD_W{1'b0}};
                    end
                end
                LOCKED: begin
                    if (!w_in_range) begin
                        w_err          = 1'b1;
                        w_good_nxt     = {GOOD_W{1'b0}};
                        w_state_nxt    = SEARCH;
                    end else if (w_match) begin
                        w_expected_nxt = w_nxt;
                        w_wrap         = w_is_zero;
                    end else begin
                        w_err          = 1'b1;
                        w_expected_nxt = w_nxt;
                        w_good_nxt     = {GOOD_W{1'b0}};
                        w_state_nxt    = ACQUIRE;
                    end
                end
                default: begin
                    w_good_nxt     = {GOOD_W{1'b0}};
                    w_state_nxt    = SEARCH;
                end
            endcase
        end else begin
            w_state_nxt    = r_state;
            w_expected_nxt = r_expected;
            w_good_nxt     = r_good;
        end
    end

    // State, tracking registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= SEARCH;
            r_expected   <= {W{1'b0}};
            r_good       <= {GOOD_W{1'b0}};
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_expected   <= w_expected_nxt;
            r_good       <= w_good_nxt;
            r_locked     <= (w_state_nxt == LOCKED);
            r_err_pulse  <= w_err;
            r_wrap_pulse <= w_wrap;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_err),
        .clr   (clear),
        .count (err_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_wrap),
        .clr   (clear),
        .count (wrap_count)
    );

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign wrap_pulse = r_wrap_pulse;

endmodule

// File: tb/tb_mod_seq_checker.sv
// Directed bench: an 8-bit-counter instance and a 2-bit-counter instance share one stimulus stream.
module tb_mod_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_count;
    logic       clear;

    logic       a_locked, a_err_pulse, a_wrap_pulse;
    logic [7:0] a_err_count, a_wrap_count;
    logic       b_locked, b_err_pulse, b_wrap_pulse;
    logic [1:0] b_err_count, b_wrap_count;

    int n_tests = 0;
    int n_fail  = 0;

    mod_seq_checker #(.MOD(14), .W(4), .LOCK_CNT(2), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count), .clear(clear),
        .locked(a_locked), .err_pulse(a_err_pulse), .wrap_pulse(a_wrap_pulse),
        .err_count(a_err_count), .wrap_count(a_wrap_count)
    );

    mod_seq_checker #(.MOD(14), .W(4), .LOCK_CNT(2), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count), .clear(clear),
        .locked(b_locked), .err_pulse(b_err_pulse), .wrap_pulse(b_wrap_pulse),
        .err_count(b_err_count), .wrap_count(b_wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests = n_tests + 1;
        if (obs !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic smp(input logic [3:0] c);
        in_valid = 1'b1;
        in_count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_count = 4'd0;
        clear    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_locked", a_locked, 0);
        chk("rst_err_pulse", a_err_pulse, 0);
        chk("rst_wrap_pulse", a_wrap_pulse, 0);
        chk("rst_err_count", a_err_count, 0);
        chk("rst_wrap_count", a_wrap_count, 0);
        rst_n = 1'b1;

        // Lock on 5,6,7
        smp(4'd5); chk("lock_after5", a_locked, 0);
        smp(4'd6); chk("lock_after6", a_locked, 0);
        smp(4'd7); chk("lock_after7", a_locked, 1);
        chk("lock_err_count", a_err_count, 0);
        smp(4'd8); chk("lock_hold8", a_locked, 1);

        // Wrap 13 -> 0
        smp(4'd9); smp(4'd10); smp(4'd11); smp(4'd12);
        smp(4'd13); chk("wrap_before", a_wrap_pulse, 0);
        smp(4'd0);  chk("wrap_at0", a_wrap_pulse, 1);
        chk("wrap_count1", a_wrap_count, 1);
        smp(4'd1);  chk("wrap_after", a_wrap_pulse, 0);
        chk("wrap_count_hold", a_wrap_count, 1);

        // Mismatch 9 where 4 expected, then relock on 10,11
        smp(4'd2); smp(4'd3);
        smp(4'd9);
        chk("mm_err_pulse", a_err_pulse, 1);
        chk("mm_err_count", a_err_count, 1);
        chk("mm_locked", a_locked, 0);
        smp(4'd10); chk("mm_pulse_1cyc", a_err_pulse, 0);
        chk("mm_relock_wait", a_locked, 0);
        smp(4'd11); chk("mm_relock", a_locked, 1);

        // Out-of-range while locked, then OOR in SEARCH is silent
        smp(4'd15);
        chk("oor_err_pulse", a_err_pulse, 1);
        chk("oor_err_count", a_err_count, 2);
        chk("oor_locked", a_locked, 0);
        smp(4'd14); chk("oor14_no_err", a_err_pulse, 0);
        smp(4'd15); chk("oor15_no_err", a_err_pulse, 0);
        chk("oor_err_count_hold", a_err_count, 2);

        // Reseed during acquire, then lock; gaps while locked
        do_reset();
        smp(4'd3);
        smp(4'd7); chk("reseed_no_err", a_err_pulse, 0);
        smp(4'd7); chk("reseed2_no_err", a_err_pulse, 0);
        smp(4'd8); chk("reseed_not_locked", a_locked, 0);
        smp(4'd9); chk("reseed_locked", a_locked, 1);
        chk("reseed_err_count", a_err_count, 0);
        idle(5);
        chk("gap_locked", a_locked, 1);
        chk("gap_err_pulse", a_err_pulse, 0);
        smp(4'd10); chk("gap_resume_locked", a_locked, 1);
        chk("gap_resume_err", a_err_pulse, 0);
        smp(4'd11); smp(4'd12); smp(4'd13);
        idle(5);
        smp(4'd0); chk("gap_wrap_pulse", a_wrap_pulse, 1);
        chk("gap_wrap_count", a_wrap_count, 1);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        chk("clear_wrap_count", a_wrap_count, 0);
        chk("clear_keeps_lock", a_locked, 1);
        chk("clear_wrap_pulse", a_wrap_pulse, 0);

        // Saturation on the 2-bit instance
        do_reset();
        smp(4'd0); smp(4'd1); smp(4'd2);
        chk("sat_locked", b_locked, 1);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                smp(4'd7);
                chk("sat_err_pulse", b_err_pulse, 1);
                smp(4'd8); smp(4'd9);
            end else begin
                smp(4'd2);
                chk("sat_err_pulse", b_err_pulse, 1);
                smp(4'd3); smp(4'd4);
            end
            chk("sat_relock", b_locked, 1);
            chk("sat_b_count", b_err_count, (i >= 2) ? 3 : i + 1);
            chk("sat_a_count", a_err_count, i + 1);
        end
        clear = 1'b1;
        smp(4'd7);
        clear = 1'b0;
        chk("clr_win_count", b_err_count, 0);
        chk("clr_win_pulse", b_err_pulse, 1);
        chk("clr_win_count_a", a_err_count, 0);
        smp(4'd8); smp(4'd9);
        chk("final_locked", b_locked, 1);

        // Reset mid-lock with a valid sample present
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_count = 4'd10;
        @(posedge clk); #1;
        chk("rst_mid_locked", b_locked, 0);
        chk("rst_mid_err_pulse", b_err_pulse, 0);
        chk("rst_mid_wrap_pulse", b_wrap_pulse, 0);
        chk("rst_mid_err_count", b_err_count, 0);
        chk("rst_mid_wrap_count", b_wrap_count, 0);
        chk("rst_mid_locked_a", a_locked, 0);
        rst_n = 1'b1;
        smp(4'd11); chk("reseed_after_rst", b_locked, 0);
        smp(4'd12); chk("reacq_after_rst", b_locked, 0);
        smp(4'd13); chk("relock_after_rst", b_locked, 1);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
